// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX frame controller and the RX datapath (line,
// configuration, checker results and enable strobes).
interface uart_rx_ctrl_if #(
    parameter int unsigned PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;
    logic                  dat_samp_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  data_valid;

    // Controller side
    modport master (
        input  RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
        output dat_samp_en, edge_cnt, bit_cnt, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en, data_valid
    );

    // Datapath side
    modport slave (
        output RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
        input  dat_samp_en, edge_cnt, bit_cnt, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en, data_valid
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: walks start/data/parity/stop with an oversampling edge
// counter, fires one-cycle checker strobes and flags clean frames with data_valid.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input logic            CLK,
    input logic            RST,
    uart_rx_ctrl_if.master bus
);

    localparam int unsigned           BIT_W    = 4;
    localparam logic [PRESCALE_W-1:0] P_MIN    = PRESCALE_W'(8);
    localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] edge_q;
    logic [BIT_W-1:0]      bit_q;
    logic [PRESCALE_W-1:0] p_lat;
    logic                  par_en_lat;
    logic                  err_q;
    logic                  samp_q;
    logic                  strt_q;
    logic                  deser_q;
    logic                  par_q;
    logic                  stp_q;
    logic                  dv_q;

    logic [PRESCALE_W-1:0] p_clamp_c;
    logic                  bit_end_c;
    logic                  pre_chk_c;

    assign p_clamp_c = (bus.Prescale < P_MIN) ? P_MIN : bus.Prescale;
    assign bit_end_c = (state != IDLE) && (edge_q == p_lat - PRESCALE_W'(1));
    // Strobes are registered one edge early so they appear on edge P-2
    assign pre_chk_c = (edge_q == p_lat - PRESCALE_W'(3));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            p_lat      <= '0;
            par_en_lat <= 1'b0;
            err_q      <= 1'b0;
            samp_q     <= 1'b0;
            strt_q     <= 1'b0;
            deser_q    <= 1'b0;
            par_q      <= 1'b0;
            stp_q      <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            strt_q  <= 1'b0;
            deser_q <= 1'b0;
            par_q   <= 1'b0;
            stp_q   <= 1'b0;
            dv_q    <= 1'b0;
            case (state)
                IDLE: begin
                    edge_q <= '0;
                    samp_q <= 1'b0;
                    if (!bus.RX_IN) begin
                        state      <= START;
                        samp_q     <= 1'b1;
                        p_lat      <= p_clamp_c;
                        par_en_lat <= bus.PAR_EN;
                    end
                end
                default: begin
                    edge_q  <= bit_end_c ? '0 : edge_q + PRESCALE_W'(1);
                    strt_q  <= pre_chk_c && (state == START);
                    deser_q <= pre_chk_c && (state == DATA);
                    par_q   <= pre_chk_c && (state == PARITY);
                    stp_q   <= pre_chk_c && (state == STOP);
                    if (bit_end_c) begin
                        case (state)
                            START: begin
                                if (bus.strt_glitch) begin
                                    state  <= IDLE;
                                    samp_q <= 1'b0;
                                end else begin
                                    state <= DATA;
                                    bit_q <= '0;
                                end
                            end
                            DATA: begin
                                if (bit_q < LAST_BIT) begin
                                    bit_q <= bit_q + BIT_W'(1);
                                end else begin
                                    state <= par_en_lat ? PARITY : STOP;
                                end
                            end
                            PARITY: begin
                                if (bus.par_err) begin
                                    err_q <= 1'b1;
                                end
                                state <= STOP;
                            end
                            STOP: begin
                                dv_q  <= !bus.stp_err && !err_q;
                                err_q <= 1'b0;
                                // Line already low at stop end: next frame starts with no idle gap
                                if (!bus.RX_IN) begin
                                    state      <= START;
                                    p_lat      <= p_clamp_c;
                                    par_en_lat <= bus.PAR_EN;
                                end else begin
                                    state  <= IDLE;
                                    samp_q <= 1'b0;
                                end
                            end
                            default: begin
                                state  <= IDLE;
                                samp_q <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.dat_samp_en = samp_q;
    assign bus.edge_cnt    = edge_q;
    assign bus.bit_cnt     = bit_q;
    assign bus.deser_en    = deser_q;
    assign bus.strt_chk_en = strt_q;
    assign bus.par_chk_en  = par_q;
    assign bus.stp_chk_en  = stp_q;
    assign bus.data_valid  = dv_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame vectors with per-cycle expected outputs,
// plus back-to-back, glitch-restart and mid-frame reset sequences.
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    typedef struct {
        int         p_in;
        int         p_exp;
        int         p_mid;
        bit         par;
        bit         glitch;
        bit         perr;
        bit         serr;
        bit         restart;
        bit         cont;
        int         abort_at;
        logic [7:0] data;
        int         dv_at;
        int         n_deser;
        int         n_stp;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   bit_hold = 0;
    int   vid = 0;
    vec_t vecs[9];

    uart_rx_ctrl_if #(.PRESCALE_W(6)) bus ();

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(int p_in, int p_exp, int p_mid, bit par, bit glitch,
                                bit perr, bit serr, bit restart, bit cont, int abort_at,
                                logic [7:0] data, int dv_at, int n_deser, int n_stp);
        vec_t v;
        v.p_in = p_in;       v.p_exp = p_exp;     v.p_mid = p_mid;
        v.par = par;         v.glitch = glitch;   v.perr = perr;
        v.serr = serr;       v.restart = restart; v.cont = cont;
        v.abort_at = abort_at; v.data = data;     v.dv_at = dv_at;
        v.n_deser = n_deser; v.n_stp = n_stp;
        return v;
    endfunction

    function automatic logic [15:0] outs();
        return {bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt, bus.deser_en,
                bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid};
    endfunction

    task automatic check_vec(input string what, input int j, input logic [15:0] act,
                             input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL vec%0d %s cycle %0d: got %h expected %h", vid, what, j, act, exp_v);
        end
    endtask

    task automatic check_int(input string what, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL vec%0d %s: got %0d expected %0d", vid, what, act, exp_v);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int f, last, n_end, b, e, p, bitc, deser_n, stp_n;
        logic samp, is_data, is_par, is_stop, dv, rx;
        logic [15:0] exp_v;
        p       = v.p_exp;
        f       = 2 + DW + int'(v.par);
        last    = v.glitch ? p : f * p;
        n_end   = v.restart ? (v.glitch ? last + 1 : last) : last + 2;
        deser_n = 0;
        stp_n   = 0;
        if (!v.cont) begin
            @(negedge CLK);
            bus.Prescale = 6'(v.p_in);
            bus.PAR_EN   = v.par;
            bus.RX_IN    = 1'b0;
        end
        for (int j = 1; j <= n_end; j++) begin
            @(negedge CLK);
            b = (j - 1) / p;
            e = (j - 1) % p;
            dv = (j == v.dv_at);
            if (j <= last) begin
                samp    = 1'b1;
                is_data = (b >= 1) && (b <= DW);
                is_par  = v.par && (b == DW + 1);
                is_stop = (b == f - 1);
                bitc    = is_data ? b - 1 : ((b == 0) ? bit_hold : DW - 1);
                exp_v = {samp, 6'(e), 4'(bitc), is_data && (e == p - 2),
                         (b == 0) && (e == p - 2), is_par && (e == p - 2),
                         is_stop && (e == p - 2), dv};
            end else begin
                bitc  = v.glitch ? bit_hold : DW - 1;
                exp_v = {1'b0, 6'd0, 4'(bitc), 4'b0000, dv};
            end
            check_vec("outputs", j, outs(), exp_v);
            deser_n += int'(bus.deser_en);
            stp_n   += int'(bus.stp_chk_en);
            if (j == v.abort_at) begin
                RST = 1'b0;
                bus.RX_IN = 1'b1;
                bus.strt_glitch = 1'b0;
                bus.par_err = 1'b0;
                bus.stp_err = 1'b0;
                #1;
                check_vec("async_reset", j, outs(), 16'h0000);
                @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                check_vec("after_reset", j, outs(), 16'h0000);
                bit_hold = 0;
                return;
            end
            if (j > last) rx = 1'b1;
            else if (b == 0) rx = 1'b0;
            else if (b <= DW) rx = v.data[b-1];
            else if (v.par && b == DW + 1) rx = ^v.data;
            else rx = 1'b1;
            bus.RX_IN       = (v.restart && j == n_end) ? 1'b0 : rx;
            bus.strt_glitch = v.glitch && (j == p);
            bus.par_err     = v.perr && (j == (DW + 2) * p);
            bus.stp_err     = v.serr && (j == f * p);
            if (v.p_mid != 0 && j == 20) bus.Prescale = 6'(v.p_mid);
        end
        if (!v.glitch) bit_hold = DW - 1;
        check_int("deser_pulses", deser_n, v.n_deser);
        check_int("stp_chk_pulses", stp_n, v.n_stp);
    endtask

    initial begin
        bus.RX_IN       = 1'b1;
        bus.Prescale    = 6'd8;
        bus.PAR_EN      = 1'b0;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;

        //        p_in pexp pmid par gl pe se rs ct abrt data   dv_at deser stp
        vecs[0] = mk(8,  8,  0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hA5,  81, 8, 1);
        vecs[1] = mk(16, 16, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h3C, 177, 8, 1);
        vecs[2] = mk(8,  8,  0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h81,   0, 8, 1);
        vecs[3] = mk(8,  8,  0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h81,  89, 8, 1);
        vecs[4] = mk(8,  8,  0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hFF,   0, 0, 0);
        vecs[5] = mk(4,  8,  0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h55,  81, 8, 1);
        vecs[6] = mk(32, 32, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h0F, 321, 8, 1);
        vecs[7] = mk(8,  8,  16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hC3,  81, 8, 1);
        vecs[8] = mk(8,  8,  0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h5A,   0, 8, 1);

        repeat (2) @(negedge CLK);
        check_vec("in_reset", 0, outs(), 16'h0000);
        RST = 1'b1;
        @(negedge CLK);
        check_vec("idle_after_reset", 0, outs(), 16'h0000);

        for (int i = 0; i < 9; i++) begin
            vid = i;
            run_vec(vecs[i]);
        end

        // Back-to-back: stop error on the first frame, second START starts at t+81
        vid = 10;
        run_vec(mk(8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 8'hA5, 0, 8, 1));
        vid = 11;
        run_vec(mk(8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h5A, 81, 8, 1));

        // Glitch, then a new low in the first IDLE cycle restarts at once
        vid = 12;
        run_vec(mk(8, 8, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'hFF, 0, 0, 0));
        vid = 13;
        run_vec(mk(8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h96, 81, 8, 1));

        // Reset at edge 3 of data bit 4, then a clean frame
        vid = 14;
        run_vec(mk(8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 44, 8'hA5, 0, 0, 0));
        vid = 15;
        run_vec(mk(8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hA5, 81, 8, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
